// File: rtl/debounce_pkg.sv
// Shared types for the key debouncer/arbiter: the per-key FSM state and the
// key-index width helper.
package debounce_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } key_state_e;

  // Width of a key index; a single key still needs one bit.
  function automatic int key_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_key.sv
// One key's debounce FSM: an input must differ from the debounced level for
// CT consecutive prescaler ticks before the level toggles.
module debounce_key
  import debounce_pkg::*;
#(
  parameter int CT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic dout,
  output logic accept
);

  localparam int CW = (CT > 1) ? $clog2(CT) : 1;

  key_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          dout_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dout  <= dout_n;
    end
  end

  // A tick seen while entering CHECK is ignored, so the first counted tick
  // always comes strictly after the input changed.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dout_n  = dout;
    accept  = 1'b0;
    unique case (state)
      STABLE: begin
        if (din != dout) begin
          state_n = CHECK;
          cnt_n   = '0;
        end
      end
      CHECK: begin
        if (din == dout) begin
          state_n = STABLE;
        end else if (tick) begin
          if (cnt == CW'(CT - 1)) begin
            dout_n  = ~dout;
            accept  = 1'b1;
            state_n = STABLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = STABLE;
    endcase
  end

endmodule

// File: rtl/debounce_arb.sv
// N-key debouncer with a round-robin change-event queue of depth one per key.
// Define DEBOUNCE_ARB_SYNC_EN to add a 2-flop synchronizer on d_i.
module debounce_arb
  import debounce_pkg::*;
#(
  parameter int N  = 4,
  parameter int CP = 50_000,
  parameter int CT = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          d_i,
  output logic [N-1:0]          d_o,
  output logic                  evt_vld,
  input  logic                  evt_rdy,
  output logic [key_w(N)-1:0]   evt_key,
  output logic                  evt_lvl,
  output logic                  evt_drop
);

  localparam int KW = key_w(N);
  localparam int PW = $clog2(CP);

  logic [PW-1:0] pre;
  logic          tick;
  logic [N-1:0]  d_s;
  logic [N-1:0]  accept;
  logic [N-1:0]  pending;
  logic [N-1:0]  clr;
  logic [KW-1:0] ptr;
  logic [KW-1:0] sel;
  logic [KW-1:0] sel_next;
  logic          found;
  logic          load;
  int            idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (pre == PW'(CP - 1)) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign tick = (pre == PW'(CP - 1));

`ifdef DEBOUNCE_ARB_SYNC_EN
  logic [N-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= d_i;
      sync2 <= sync1;
    end
  end

  assign d_s = sync2;
`else
  assign d_s = d_i;
`endif

  for (genvar g = 0; g < N; g++) begin : g_key
    debounce_key #(.CT(CT)) u_key (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .din    (d_s[g]),
      .dout   (d_o[g]),
      .accept (accept[g])
    );
  end

  // First pending key at or after ptr, wrapping round.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = KW'(idx);
      end
    end
  end

  assign load     = !evt_vld || evt_rdy;
  assign sel_next = (sel == KW'(N - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    clr = '0;
    if (load && found) begin
      clr[sel] = 1'b1;
    end
  end

  // A fresh acceptance beats a same-cycle load-clear, so the newer level is
  // never lost; only a toggle on a key that stays pending counts as a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      ptr      <= '0;
      evt_vld  <= 1'b0;
      evt_key  <= '0;
      evt_lvl  <= 1'b0;
      evt_drop <= 1'b0;
    end else begin
      pending  <= (pending & ~clr) | accept;
      evt_drop <= |(accept & pending & ~clr);
      if (load) begin
        if (found) begin
          evt_vld <= 1'b1;
          evt_key <= sel;
          evt_lvl <= d_o[sel];
          ptr     <= sel_next;
        end else begin
          evt_vld <= 1'b0;
        end
      end
    end
  end

endmodule
